// File: rtl/alu_pkg.sv
// Shared types for the iterative execute-stage ALU: op codes, default width and FSM states.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_OP_W       = 4;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_BEQ  = 4'b1000,
        OP_BNE  = 4'b1001,
        OP_BLT  = 4'b1010,
        OP_BGE  = 4'b1011,
        OP_SLT  = 4'b1100,
        OP_RSV0 = 4'b1101,
        OP_RSV1 = 4'b1110,
        OP_LUI  = 4'b1111
    } alu_op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_e;

    function automatic logic is_shift_op(alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shift engine: one bit per cycle by default, single-cycle barrel shifter when
// ALU_BARREL_SHIFT_EN is defined.
module alu_shift_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [3:0]                    op,
    input  logic [DATA_WIDTH-1:0]         a,
    input  logic [$clog2(DATA_WIDTH)-1:0] amt,
    output logic                          done,
    output logic [DATA_WIDTH-1:0]         result
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

`ifdef ALU_BARREL_SHIFT_EN

    always_comb begin
        case (alu_op_e'(op))
            OP_SLL:  result = a << amt;
            OP_SRL:  result = a >> amt;
            OP_SRA:  result = $unsigned($signed(a) >>> amt);
            default: result = a;
        endcase
    end

    assign done = 1'b1;

`else

    alu_op_e               op_r;
    logic [DATA_WIDTH-1:0] work;
    logic [SHAMT_W-1:0]    count;

    function automatic logic [DATA_WIDTH-1:0] step(logic [DATA_WIDTH-1:0] w, alu_op_e o);
        logic [DATA_WIDTH-1:0] r;
        case (o)
            OP_SLL:  r = {w[DATA_WIDTH-2:0], 1'b0};
            OP_SRA:  r = {w[DATA_WIDTH-1], w[DATA_WIDTH-1:1]};
            default: r = {1'b0, w[DATA_WIDTH-1:1]};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= amt;
        end else if (count != '0) begin
            count <= count - SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            work <= a;
            op_r <= alu_op_e'(op);
        end else if (count != '0) begin
            work <= step(work, op_r);
        end
    end

    // The final shift is folded into the Result load, so completion is flagged one step early.
    assign done   = (count == SHAMT_W'(1));
    assign result = step(work, op_r);

`endif

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with start/done handshake; shifts iterate unless ALU_BARREL_SHIFT_EN is defined.
module alu_iter_exec
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = ALU_DATA_WIDTH,
    parameter int OPCODE_LENGTH = ALU_OP_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     Ready,
    output logic                     Done,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    alu_op_e               op;
    logic [SHAMT_W-1:0]    amt;
    logic                  accept;
    logic                  shift_req;
    logic                  shift_start;
    logic                  shift_done;
    logic                  load_result;
    logic [DATA_WIDTH-1:0] shift_result;
    logic [DATA_WIDTH-1:0] result_next;

    assign op        = alu_op_e'(Operation[3:0]);
    assign amt       = SrcB[SHAMT_W-1:0];
    assign shift_req = is_shift_op(op);

    function automatic logic [DATA_WIDTH-1:0] alu_compute(alu_op_e o,
                                                          logic [DATA_WIDTH-1:0] a,
                                                          logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (o)
            OP_AND:         r = a & b;
            OP_OR:          r = a | b;
            OP_ADD:         r = a + b;
            OP_SUB:         r = a - b;
            OP_XOR:         r = a ^ b;
            OP_SLT, OP_BLT: r = DATA_WIDTH'($signed(a) < $signed(b));
            OP_BGE:         r = DATA_WIDTH'(!($signed(a) < $signed(b)));
            OP_BEQ:         r = DATA_WIDTH'(a == b);
            OP_BNE:         r = DATA_WIDTH'(a != b);
            OP_LUI:         r = b;
            // Only reached for a zero shift amount; real shifts go through the shift unit.
            OP_SLL, OP_SRL, OP_SRA: r = a;
            default:        r = '0;
        endcase
        return r;
    endfunction

    alu_shift_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .start  (shift_start),
        .op     (Operation[3:0]),
        .a      (SrcA),
        .amt    (amt),
        .done   (shift_done),
        .result (shift_result)
    );

`ifdef ALU_BARREL_SHIFT_EN

    assign Ready       = ~reset;
    assign accept      = Start & Ready;
    assign shift_start = 1'b0;
    assign load_result = accept;
    assign result_next = shift_req ? shift_result : alu_compute(op, SrcA, SrcB);

`else

    alu_state_e state;
    alu_state_e state_next;

    // Ready is masked by reset so a Start coinciding with reset is never accepted.
    assign Ready  = (state == IDLE) & ~reset;
    assign accept = Start & Ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        shift_start = 1'b0;
        load_result = 1'b0;
        result_next = alu_compute(op, SrcA, SrcB);
        case (state)
            IDLE: begin
                if (accept) begin
                    if (shift_req && (amt != '0)) begin
                        shift_start = 1'b1;
                        state_next  = SHIFT;
                    end else begin
                        load_result = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (shift_done) begin
                    load_result = 1'b1;
                    result_next = shift_result;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            Done   <= 1'b0;
            Result <= '0;
        end else begin
            Done <= load_result;
            if (load_result) begin
                Result <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: vector table, corner-case sequences and randomized ops.
module tb_alu_iter_exec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Operation = '0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        Ready;
    logic        Done;
    logic [31:0] Result;

    int vectors = 0;
    int miscompares = 0;

    alu_iter_exec #(
        .DATA_WIDTH(32),
        .OPCODE_LENGTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Operation (Operation),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Ready     (Ready),
        .Done      (Done),
        .Result    (Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference result straight from the op-code table.
    function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0110: return a ^ b;
            4'b0100: return a << sh;
            4'b0101: return a >> sh;
            4'b0111: return $unsigned($signed(a) >>> sh);
            4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1111: return b;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            4'b1001: return (a != b) ? 32'd1 : 32'd0;
            4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1011: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Samples after the accept edge until Done is seen (first sample counts as 1).
    function automatic int model_lat(logic [3:0] op, logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
`endif
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!Ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!Ready) check("ready_timeout", {31'd0, Ready}, 32'd1);
    endtask

    task automatic issue(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        int lat;
        int rdy_low;
        int elat;
        logic [31:0] res;
        elat = model_lat(op, b);
        wait_ready();
        Operation = op; SrcA = a; SrcB = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
        lat = 1; rdy_low = 0;
        while (!Done && lat < 64) begin
            if (!Ready) rdy_low++;
            @(posedge clk); #1;
            lat++;
        end
        if (!Done) begin
            check({name, "_done_timeout"}, {31'd0, Done}, 32'd1);
        end else begin
            res = Result;
            check({name, "_result"}, res, model(op, a, b));
            check({name, "_latency"}, lat, elat);
            check({name, "_ready_low"}, rdy_low, elat - 1);
            @(posedge clk); #1;
            check({name, "_done_pulse"}, {31'd0, Done}, 32'd0);
            check({name, "_held"}, Result, res);
        end
    endtask

    vec_t tbl[$];

    initial begin
        int lat;
        int rl;
        logic [31:0] ba [8];
        logic [31:0] bb [8];

        tbl.push_back('{4'b0010, 32'd5,        32'd7,        32'd12});
        tbl.push_back('{4'b0011, 32'd3,        32'd5,        32'hFFFF_FFFE});
        tbl.push_back('{4'b1100, 32'hFFFF_FFFF, 32'd1,       32'd1});
        tbl.push_back('{4'b1111, 32'd0,        32'h1234_5000, 32'h1234_5000});
        tbl.push_back('{4'b0111, 32'h8000_0000, 32'd4,       32'hF800_0000});
        tbl.push_back('{4'b1000, 32'd9,        32'd9,        32'd1});
        tbl.push_back('{4'b1001, 32'd9,        32'd9,        32'd0});
        tbl.push_back('{4'b1010, 32'hFFFF_FFFF, 32'd1,       32'd1});
        tbl.push_back('{4'b1011, 32'hFFFF_FFFF, 32'd1,       32'd0});
        tbl.push_back('{4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F});
        tbl.push_back('{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F});
        tbl.push_back('{4'b0110, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F});
        tbl.push_back('{4'b1101, 32'd5,        32'd7,        32'd0});
        tbl.push_back('{4'b1110, 32'd5,        32'd7,        32'd0});
        tbl.push_back('{4'b0101, 32'h8000_0000, 32'd8,       32'h0080_0000});
        tbl.push_back('{4'b0100, 32'd1,        32'd31,       32'h8000_0000});
        tbl.push_back('{4'b0100, 32'hDEAD_BEEF, 32'd32,      32'hDEAD_BEEF});
        tbl.push_back('{4'b1100, 32'd1,        32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{4'b0010, 32'hFFFF_FFFF, 32'd2,       32'd1});
        tbl.push_back('{4'b0111, 32'h7FFF_FFF0, 32'h24,      32'h07FF_FFFF});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, Ready}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_result", Result, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, Ready}, 32'd1);
        @(posedge clk); #1;

        // Table vectors: the hand-computed expectation and the model must both hold
        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("table%0d_model", i), model(tbl[i].op, tbl[i].a, tbl[i].b), tbl[i].exp);
            issue($sformatf("table%0d", i), tbl[i].op, tbl[i].a, tbl[i].b);
        end

`ifndef ALU_BARREL_SHIFT_EN
        // SRA with Start pulses and operand churn while busy
        wait_ready();
        Operation = 4'b0111; SrcA = 32'h8000_0000; SrcB = 32'd4; Start = 1'b1;
        @(posedge clk); #1;
        lat = 1; rl = 0;
        while (!Done && lat < 64) begin
            if (!Ready) rl++;
            Start = (lat < 4);
            Operation = 4'b0010; SrcA = $urandom; SrcB = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        Start = 1'b0;
        check("busy_sra_latency", lat, 5);
        check("busy_sra_ready_low", rl, 4);
        check("busy_sra_result", Result, 32'hF800_0000);
        @(posedge clk); #1;
        check("busy_sra_no_extra_done", {31'd0, Done}, 32'd0);

        // Reset three cycles after accepting a long shift
        wait_ready();
        Operation = 4'b0100; SrcA = 32'd1; SrcB = 32'd31; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("abort_no_done%0d", c), {31'd0, Done}, 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_result", Result, 32'd0);
        reset = 1'b0;
        #1;
        check("abort_ready", {31'd0, Ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("abort_late_done%0d", c), {31'd0, Done}, 32'd0);
        end
        issue("after_abort_add", 4'b0010, 32'd2, 32'd2);
`endif

        // Start together with reset is dropped
        Operation = 4'b0010; SrcA = 32'd100; SrcB = 32'd1; Start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; reset = 1'b0;
        @(posedge clk); #1;
        check("rst_start_done", {31'd0, Done}, 32'd0);
        check("rst_start_result", Result, 32'd0);

        // Back-to-back ADDs, one accepted per cycle
        wait_ready();
        for (int i = 0; i < 8; i++) begin
            ba[i] = $urandom;
            bb[i] = $urandom;
        end
        Start = 1'b1; Operation = 4'b0010;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                check($sformatf("b2b%0d_done", i - 1), {31'd0, Done}, 32'd1);
                check($sformatf("b2b%0d_result", i - 1), Result, ba[i - 1] + bb[i - 1]);
            end
            if (i < 8) begin
                SrcA = ba[i]; SrcB = bb[i];
                check($sformatf("b2b%0d_ready", i), {31'd0, Ready}, 32'd1);
                @(posedge clk); #1;
            end
        end
        Start = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_done", {31'd0, Done}, 32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 120; i++) begin
            issue($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
